mem_access_stage: RTL and testbench

- Pipeline memory stage, directly downstream of the execute stage.
- Consumes the execute result (address or ALU value), the store data and the load/store control bits.
- Drives a variable-latency data-memory request/ready port, stalls upstream while an access is outstanding, and formats load data into the write-back result.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_access_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Pipeline memory stage. Passes non-memory results through with
//            one cycle of latency. Issues memory operations on a
//            variable-latency request/ready data-memory port and stalls the
//            upstream stage while an access is outstanding. Formats load
//            data for write-back and aborts an access that never completes.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            ex_valid, mem_read, mem_write, funct3, alu_data, memory_data
//                                - execute-stage result and memory control
//            stall               - combinational upstream hold
//            wb_valid, wb_data   - registered write-back result
//            misaligned          - one-cycle pulse, misaligned access dropped
//            bus_error           - one-cycle pulse, access aborted by timeout
//            dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
//            dmem_ready, dmem_rdata - data-memory request/ready port
// Options  : `define MISALIGN_CHECK_EN enables misalignment detection and
//            the misaligned pulse. Without it, misaligned is tied to 0 and
//            accesses use the truncated word address.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_lane;
    logic [2:0]       r_funct3;
    logic             r_wb_valid;
    logic [31:0]      r_wb_data;
    logic             r_bus_error;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;

    // Control strobes produced by the FSM for the datapath registers
    logic w_pass;
    logic w_capture;
    logic w_done;
    logic w_abort;

    logic        w_is_mem;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lbyte;
    logic [15:0] w_lhalf;
    logic [31:0] w_load_data;

    assign w_is_mem = mem_read | mem_write;

    // Size code: funct3[1:0] = 00 byte, 01 half, anything else word
    // (invalid codes 011/110/111 therefore behave as word accesses).
`ifdef MISALIGN_CHECK_EN
    logic w_misaligned;
    logic w_drop;
    logic r_misaligned;

    always_comb begin
        w_misaligned = 1'b0;
        case (funct3[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = alu_data[0];
            default: w_misaligned = (alu_data[1:0] != 2'b00);
        endcase
    end

    assign misaligned = r_misaligned;
`else
    assign misaligned = 1'b0;
`endif

    // Store lane steering; lanes are replicated so the byte enables alone
    // select which copy the memory writes.
    always_comb begin
        w_be    = 4'hF;
        w_wdata = memory_data;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_data[1:0];
                w_wdata = {4{memory_data[7:0]}};
            end
            2'b01: begin
                w_be    = alu_data[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{memory_data[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = memory_data;
            end
        endcase
    end

    // Load lane selection from the address bits latched at capture
    always_comb begin
        w_lbyte = dmem_rdata[7:0];
        case (r_lane)
            2'd0:    w_lbyte = dmem_rdata[7:0];
            2'd1:    w_lbyte = dmem_rdata[15:8];
            2'd2:    w_lbyte = dmem_rdata[23:16];
            default: w_lbyte = dmem_rdata[31:24];
        endcase
        w_lhalf = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        w_load_data = dmem_rdata;
        case (r_funct3[1:0])
            2'b00:   w_load_data = r_funct3[2] ? {24'd0, w_lbyte}
                                               : {{24{w_lbyte[7]}}, w_lbyte};
            2'b01:   w_load_data = r_funct3[2] ? {16'd0, w_lhalf}
                                               : {{16{w_lhalf[15]}}, w_lhalf};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, stall and datapath strobes
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        w_pass       = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
`ifdef MISALIGN_CHECK_EN
        w_drop       = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (ex_valid) begin
                    if (!w_is_mem) begin
                        w_pass = 1'b1;
`ifdef MISALIGN_CHECK_EN
                    end else if (w_misaligned) begin
                        w_drop = 1'b1;
`endif
                    end else begin
                        w_capture    = 1'b1;
                        stall        = 1'b1;
                        w_next_state = REQ;
                    end
                end
            end
            REQ: begin
                // Ready takes priority over a timeout in the same cycle
                stall = !dmem_ready;
                if (dmem_ready) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end else if (r_count == CNT_LAST) begin
                    w_abort      = 1'b1;
                    stall        = 1'b0;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_lane      <= 2'd0;
            r_funct3    <= 3'd0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= 32'd0;
            r_bus_error <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_bus_error <= 1'b0;
            if (w_pass) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= alu_data;
            end
            if (w_capture) begin
                r_addr   <= {alu_data[31:2], 2'b00};
                r_we     <= mem_write;
                r_be     <= w_be;
                r_wdata  <= w_wdata;
                r_lane   <= alu_data[1:0];
                r_funct3 <= funct3;
                r_count  <= '0;
            end
            if (w_done) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= r_we ? 32'd0 : w_load_data;
                r_count    <= '0;
            end else if (w_abort) begin
                r_bus_error <= 1'b1;
                r_count     <= '0;
            end else if (r_state == REQ) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_drop;
        end
    end
`endif

    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign bus_error  = r_bus_error;
    assign dmem_req   = (r_state == REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. Directed scenarios
//            followed by random instructions, each compared against a
//            behavioural model of the memory stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_data;
    logic [31:0] memory_data;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .alu_data    (alu_data),
        .memory_data (memory_data),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .misaligned  (misaligned),
        .bus_error   (bus_error),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_CHECK_EN
        return (a % size_bytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int          sz;
        logic [31:0] v;
        sz = size_bytes(f3);
        if (sz == 4) return rd;
        v = rd >> (8 * ((a % 4) / sz * sz));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int first;
        logic [3:0] m;
        sz    = size_bytes(f3);
        first = (a % 4) / sz * sz;
        m     = 4'd0;
        for (int b = 0; b < 4; b++)
            if (b >= first && b < first + sz) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] md);
        int sz;
        sz = size_bytes(f3);
        if (sz == 1) return (md & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (md & 32'hFFFF) * 32'h0001_0001;
        return md;
    endfunction

    // ---------------- one instruction through the stage ----------------
    // delay = REQ cycles without ready before ready is given; >= TO times out
    task automatic run_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] md, input int delay,
                          input logic [31:0] rdata);
        bit is_mem;
        bit mis;
        bit rdy;
        is_mem = rd | wr;
        mis    = is_mem && model_misaligned(f3, alu);

        @(negedge clk);
        ex_valid    = 1'b1;
        mem_read    = rd;
        mem_write   = wr;
        funct3      = f3;
        alu_data    = alu;
        memory_data = md;
        dmem_ready  = 1'b0;
        dmem_rdata  = $urandom;
        #1;
        check({nm, ":stall_issue"}, {31'd0, stall}, {31'd0, is_mem && !mis});
        @(posedge clk);
        #1;
        if (!is_mem) begin
            check({nm, ":wb_valid"}, {31'd0, wb_valid}, 32'd1);
            check({nm, ":wb_data"}, wb_data, alu);
            check({nm, ":no_req"}, {31'd0, dmem_req}, 32'd0);
        end else if (mis) begin
            check({nm, ":misaligned"}, {31'd0, misaligned}, 32'd1);
            check({nm, ":mis_wb_valid"}, {31'd0, wb_valid}, 32'd0);
            check({nm, ":mis_no_req"}, {31'd0, dmem_req}, 32'd0);
        end else begin
            for (int k = 0; k < TO; k++) begin
                @(negedge clk);
                rdy        = (k == delay);
                dmem_ready = rdy;
                dmem_rdata = rdy ? rdata : $urandom;
                #1;
                check({nm, ":req"}, {31'd0, dmem_req}, 32'd1);
                check({nm, ":addr"}, dmem_addr, alu & 32'hFFFF_FFFC);
                check({nm, ":we"}, {31'd0, dmem_we}, {31'd0, wr});
                if (wr) begin
                    check({nm, ":be"}, {28'd0, dmem_be}, {28'd0, model_be(f3, alu)});
                    check({nm, ":wdata"}, dmem_wdata, model_wdata(f3, md));
                end
                check({nm, ":stall_req"}, {31'd0, stall}, {31'd0, !rdy && k != TO - 1});
                @(posedge clk);
                #1;
                if (rdy) begin
                    check({nm, ":wb_valid"}, {31'd0, wb_valid}, 32'd1);
                    check({nm, ":wb_data"}, wb_data, wr ? 32'd0 : model_load(f3, alu, rdata));
                    break;
                end else if (k == TO - 1) begin
                    check({nm, ":bus_error"}, {31'd0, bus_error}, 32'd1);
                    check({nm, ":to_wb_valid"}, {31'd0, wb_valid}, 32'd0);
                    check({nm, ":to_req"}, {31'd0, dmem_req}, 32'd0);
                end else begin
                    check({nm, ":wait_wb_valid"}, {31'd0, wb_valid}, 32'd0);
                end
            end
        end
        // Idle cycle: pulses clear, and a stray ready in IDLE does nothing
        @(negedge clk);
        ex_valid   = 1'b0;
        dmem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check({nm, ":idle_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        check({nm, ":idle_req"}, {31'd0, dmem_req}, 32'd0);
        check({nm, ":idle_pulses"}, {30'd0, misaligned, bus_error}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        ex_valid    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        funct3      = 3'd0;
        alu_data    = 32'd0;
        memory_data = 32'd0;
        dmem_ready  = 1'b0;
        dmem_rdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_pulses", {30'd0, misaligned, bus_error}, 32'd0);
        check("rst_req_we", {30'd0, dmem_req, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed scenarios
        run_op("add",  1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 0, 32'd0);
        run_op("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 3, 32'h80FF_FFFF);
        run_op("sh",   1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'hABCD_1234, 0, 32'd0);
        run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 0, 32'h1122_3344);
        run_op("lw_to", 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, TO + 5, 32'd0);
        run_op("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0042, 32'd0, 1, 32'h8765_4321);
        run_op("rw_st", 1'b1, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 0, 32'd0);
        run_op("ready_last", 1'b1, 1'b0, 3'b110, 32'h0000_0800, 32'd0, TO - 1, 32'hCAFE_F00D);

        // Reset in the middle of an access; a late ready must be ignored
        @(negedge clk);
        ex_valid  = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        funct3    = 3'b010;
        alu_data  = 32'h0000_0500;
        @(posedge clk);
        #1;
        check("rstmid_req_on", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_req_off", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        ex_valid   = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rstmid_req_idle", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        dmem_ready = 1'b0;

        // Random instructions
        for (int i = 0; i < 150; i++) begin
            logic        rd;
            logic        wr;
            int          dly;
            int          kind;
            kind = $urandom_range(0, 3);
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind >= 2);
            dly  = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4);
            run_op("rnd", rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, dly, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
